// File: rtl/mmio_pkg.sv
// ============================================================================
// Module  : mmio_pkg
// Brief   : Register offsets, CTRL bit indices and duty struct for the
//           memory-mapped LED/RGB PWM peripheral.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package mmio_pkg;

  localparam logic [3:0] CTRL_OFF   = 4'h0;
  localparam logic [3:0] DUTY_OFF   = 4'h4;
  localparam logic [3:0] PHASE_OFF  = 4'h8;
  localparam logic [3:0] MILLIS_OFF = 4'hC;

  localparam int CTRL_LED_BIT = 0;
  localparam int CTRL_PWM_BIT = 1;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } duty_t;

endpackage

`default_nettype wire

// File: rtl/pwm_channel.sv
// ============================================================================
// Module  : pwm_channel
// Brief   : One PWM colour channel: shadowed active duty, registered active-low pin.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module pwm_channel (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] phase,
  input  logic [7:0] stage,
  input  logic       load,
  input  logic       en,
  output logic       pin
);

  logic [7:0] r_active;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active <= '0;
      pin      <= 1'b1;
    end else begin
      if (load)
        r_active <= stage;
      pin <= ~(en && (phase < r_active));
    end
  end

endmodule

`default_nettype wire

// File: rtl/mmio_led_pwm.sv
// ============================================================================
// Module  : mmio_led_pwm
// Brief   : 16-byte MMIO window driving an active-low user LED and 8-bit RGB PWM.
//           Optional millisecond counter at 0xC: MMIO_LED_PWM_MILLIS_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module mmio_led_pwm
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FFF0,
  parameter int          PRESCALE  = 46,
  parameter int          CLK_HZ    = 12_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        ren,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        LED,
  output logic        RGB_R,
  output logic        RGB_G,
  output logic        RGB_B
);

  logic        w_sel;
  logic [3:0]  w_off;
  logic        w_wr;
  logic        w_rd;
  logic [1:0]  w_ctrl_next;
  logic [31:0] w_rmux;
  logic [31:0] w_millis;
  logic        w_tick;
  logic        w_load;
  logic        w_unused;
  logic [2:0]  w_pins;
  logic [2:0][7:0] w_stage;

  logic [1:0]  r_ctrl;
  duty_t       r_stage;
  logic [31:0] r_pre;
  logic [7:0]  r_phase;

  assign w_sel = (addr[31:4] == BASE_ADDR[31:4]);
  assign w_off = {addr[3:2], 2'b00};
  assign w_wr  = w_sel && (wmask != 4'b0000);
  assign w_rd  = w_sel && ren;

  always_comb begin
    w_ctrl_next = r_ctrl;
    if (w_wr && (w_off == CTRL_OFF) && wmask[0])
      w_ctrl_next = wdata[1:0];
  end

  // LED follows the store in the same edge so it is visible the next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl  <= '0;
      r_stage <= '0;
      LED     <= 1'b1;
    end else begin
      r_ctrl <= w_ctrl_next;
      LED    <= ~w_ctrl_next[CTRL_LED_BIT];
      if (w_wr && (w_off == DUTY_OFF)) begin
        if (wmask[0]) r_stage.b <= wdata[7:0];
        if (wmask[1]) r_stage.g <= wdata[15:8];
        if (wmask[2]) r_stage.r <= wdata[23:16];
      end
    end
  end

  assign w_tick = (r_pre == 32'(PRESCALE));
  assign w_load = (w_tick && (r_phase == 8'hFF)) || !r_ctrl[CTRL_PWM_BIT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre   <= '0;
      r_phase <= '0;
    end else begin
      if (w_tick) begin
        r_pre   <= '0;
        r_phase <= r_phase + 8'd1;
      end else begin
        r_pre <= r_pre + 32'd1;
      end
    end
  end

  always_comb begin
    w_rmux = '0;
    case (w_off)
      CTRL_OFF:   w_rmux = {30'b0, r_ctrl};
      DUTY_OFF:   w_rmux = {8'b0, r_stage};
      PHASE_OFF:  w_rmux = {24'b0, r_phase};
      MILLIS_OFF: w_rmux = w_millis;
      default:    w_rmux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= w_rd;
      rdata  <= w_rd ? w_rmux : 32'b0;
    end
  end

  assign w_stage = {r_stage.r, r_stage.g, r_stage.b};

  generate
    for (genvar i = 0; i < 3; i++) begin : g_ch
      pwm_channel u_ch (
        .clk   (clk),
        .reset (reset),
        .phase (r_phase),
        .stage (w_stage[i]),
        .load  (w_load),
        .en    (r_ctrl[CTRL_PWM_BIT]),
        .pin   (w_pins[i])
      );
    end
  endgenerate

  assign {RGB_R, RGB_G, RGB_B} = w_pins;

`ifdef MMIO_LED_PWM_MILLIS_EN
  localparam int MS_DIV = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;

  logic [31:0] r_ms_sub;
  logic [31:0] r_millis;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ms_sub <= '0;
      r_millis <= '0;
    end else if (r_ms_sub == 32'(MS_DIV - 1)) begin
      r_ms_sub <= '0;
      r_millis <= r_millis + 32'd1;
    end else begin
      r_ms_sub <= r_ms_sub + 32'd1;
    end
  end

  assign w_millis = r_millis;
  assign w_unused = ^{addr[1:0], wdata[31:24]};
`else
  assign w_millis = '0;
  assign w_unused = ^{addr[1:0], wdata[31:24], CLK_HZ[0]};
`endif

endmodule

`default_nettype wire
